// File: rtl/instr_issue_seq_pkg.sv
// Shared definitions for the instruction issue sequencer:
// NOP encoding, FSM state encoding and a phase-width helper.
package instr_issue_seq_pkg;

  localparam logic [31:0] NOP_WORD = 32'h4000_0009;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int phase_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/instr_issue_seq_if.sv
// Control/program-load and issue bundle between a driver
// and the instruction issue sequencer.
interface instr_issue_seq_if #(
  parameter int DataSize = 32,
  parameter int AddrSize = 4
);

  logic                load_en;
  logic [AddrSize-1:0] load_addr;
  logic [DataSize-1:0] load_data;
  logic [AddrSize:0]   prog_len;
  logic                start;
  logic                stop;
  logic [DataSize-1:0] instruction;
  logic                issue;
  logic [AddrSize-1:0] pc;
  logic                busy;
  logic                done;

  modport master (
    output load_en, load_addr, load_data,
    output prog_len, start, stop,
    input  instruction, issue, pc, busy, done
  );

  modport slave (
    input  load_en, load_addr, load_data,
    input  prog_len, start, stop,
    output instruction, issue, pc, busy, done
  );

endinterface

// File: rtl/instr_issue_seq_prog_rom.sv
// Program store: register array, synchronous write,
// asynchronous read. Deliberately not reset.
module instr_issue_seq_prog_rom #(
  parameter int DataSize = 32,
  parameter int AddrSize = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AddrSize-1:0] waddr,
  input  logic [DataSize-1:0] wdata,
  input  logic [AddrSize-1:0] raddr,
  output logic [DataSize-1:0] rdata
);

  logic [DataSize-1:0] mem_q [2**AddrSize];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_issue_seq.sv
// Steps through a loaded program, holding each word for
// HoldCycles clocks, then drains with NOPs and flags done.
module instr_issue_seq
  import instr_issue_seq_pkg::*;
#(
  parameter int DataSize   = 32,
  parameter int AddrSize   = 4,
  parameter int HoldCycles = 4,
  parameter logic [DataSize-1:0] NopWord =
    DataSize'(NOP_WORD)
) (
  input  logic clk,
  input  logic reset,
  instr_issue_seq_if.slave bus
);

  localparam int PW = phase_w(HoldCycles);
  localparam int LW = AddrSize + 1;
  localparam logic [PW-1:0] PH_LAST =
    PW'(HoldCycles - 1);

  state_e              state_q, state_d;
  logic [AddrSize-1:0] pc_q, pc_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [LW-1:0]       len_q, len_d;
  logic [DataSize-1:0] instr_q, instr_d;
  logic                issue_q, issue_d;

  logic [AddrSize-1:0] rd_addr;
  logic [DataSize-1:0] rd_data;
  logic busy, go, ph_last, last_word, we;

  assign busy = (state_q == S_ISSUE) ||
                (state_q == S_DRAIN);
  assign go   = bus.start &&
                ((state_q == S_IDLE) ||
                 (state_q == S_DONE));
  assign we   = bus.load_en && !busy;

  assign ph_last   = (phase_q == PH_LAST);
  assign last_word = ({1'b0, pc_q} == len_q - LW'(1));

  // Single read port: word 0 on start, next word mid-run
  assign rd_addr = (state_q == S_ISSUE) ?
                   pc_q + AddrSize'(1) : '0;

  instr_issue_seq_prog_rom #(
    .DataSize (DataSize),
    .AddrSize (AddrSize)
  ) u_rom (
    .clk   (clk),
    .we    (we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      phase_q <= '0;
      len_q   <= '0;
      instr_q <= NopWord;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      phase_q <= phase_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      issue_q <= issue_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start)
          state_d = (bus.prog_len == '0) ?
                    S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (ph_last && last_word) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (ph_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.start)
          state_d = (bus.prog_len == '0) ?
                    S_DONE : S_ISSUE;
        else if (bus.load_en)
          state_d = S_IDLE;
      end
    endcase
    if (bus.stop) state_d = S_IDLE;
  end

  always_comb begin
    pc_d    = pc_q;
    phase_d = phase_q;
    len_d   = len_q;
    instr_d = instr_q;
    issue_d = 1'b0;
    if (bus.stop) begin
      pc_d    = '0;
      phase_d = '0;
      instr_d = NopWord;
    end else if (go) begin
      len_d   = bus.prog_len;
      pc_d    = '0;
      phase_d = '0;
      issue_d = (bus.prog_len != '0);
      instr_d = issue_d ? rd_data : NopWord;
    end else if (state_q == S_ISSUE) begin
      if (!ph_last) begin
        phase_d = phase_q + PW'(1);
      end else begin
        phase_d = '0;
        if (last_word) begin
          instr_d = NopWord;
        end else begin
          pc_d    = pc_q + AddrSize'(1);
          instr_d = rd_data;
          issue_d = 1'b1;
        end
      end
    end else if (state_q == S_DRAIN) begin
      phase_d = ph_last ? '0 : phase_q + PW'(1);
    end
  end

  assign bus.instruction = instr_q;
  assign bus.issue       = issue_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy;
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_issue_seq.sv
// Bench for instr_issue_seq: directed scenarios plus random
// traffic against a timing-formula reference model.
module tb_instr_issue_seq;

  localparam int H = 4;
  localparam logic [31:0] NOP = 32'h4000_0009;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_run = 0;
  int n_fail = 0;

  instr_issue_seq_if #(.DataSize(32), .AddrSize(4)) bus();

  instr_issue_seq #(
    .DataSize   (32),
    .AddrSize   (4),
    .HoldCycles (H),
    .NopWord    (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int m_t = 0;
  int m_len = 0;
  int m_pc = 0;
  logic [31:0] m_mem [16];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_ins;
    int e_iss, e_pc, e_busy, e_done, k;
    e_ins = NOP; e_iss = 0; e_pc = m_pc;
    e_busy = 0; e_done = 0;
    case (m_mode)
      M_RUN: begin
        e_busy = 1;
        if (m_t < m_len * H) begin
          k = m_t / H;
          e_ins = m_mem[k];
          e_iss = (m_t % H == 0) ? 1 : 0;
          e_pc = k;
        end else begin
          e_pc = m_len - 1;
        end
      end
      M_DONE: e_done = 1;
      default: ;
    endcase
    chk("instr", bus.instruction, e_ins);
    chk("issue", 32'(bus.issue), e_iss);
    chk("pc", 32'(bus.pc), e_pc);
    chk("busy", 32'(bus.busy), e_busy);
    chk("done", 32'(bus.done), e_done);
  endtask

  task automatic begin_run();
    m_len = int'(bus.prog_len);
    m_pc = 0;
    m_t = 0;
    m_mode = (m_len == 0) ? M_DONE : M_RUN;
  endtask

  task automatic model_edge();
    bit wr_ok;
    wr_ok = (m_mode != M_RUN);
    if (bus.stop) begin
      m_mode = M_IDLE;
      m_pc = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.start) begin_run();
        M_DONE: begin
          if (bus.start) begin_run();
          else if (bus.load_en) m_mode = M_IDLE;
        end
        M_RUN: begin
          m_t++;
          if (m_t == (m_len + 1) * H) begin
            m_mode = M_DONE;
            m_pc = m_len - 1;
          end
        end
        default: ;
      endcase
    end
    if (bus.load_en && wr_ok)
      m_mem[bus.load_addr] = bus.load_data;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.load_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic load(input int a, input logic [31:0] d);
    bus.load_en = 1'b1;
    bus.load_addr = a[3:0];
    bus.load_data = d;
    cyc();
  endtask

  task automatic run(input int len);
    bus.prog_len = len[4:0];
    bus.start = 1'b1;
    cyc();
  endtask

  int issues, done_at;

  initial begin
    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
    bus.prog_len = 0; bus.start = 0; bus.stop = 0;
    @(negedge clk);
    chk("rst_instr", bus.instruction, NOP);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pc", 32'(bus.pc), 0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) load(i, $urandom);

    // T2: three-word program
    load(0, 32'h4400_00C8);
    load(1, 32'h5002_0064);
    load(2, 32'h4040_0020);
    run(3);
    issues = int'(bus.issue);
    done_at = -1;
    for (int i = 1; i < 20; i++) begin
      cyc();
      issues += int'(bus.issue);
      if (bus.done && done_at < 0) done_at = i;
    end
    chk("t2_issues", issues, 3);
    chk("t2_done_at", done_at, 16);

    // T3: stop during word1 phase2, then rerun
    run(3);
    cycles(6);
    chk("t3_pre_pc", 32'(bus.pc), 1);
    bus.stop = 1'b1;
    cyc();
    chk("t3_instr", bus.instruction, NOP);
    chk("t3_busy", 32'(bus.busy), 0);
    chk("t3_pc", 32'(bus.pc), 0);
    cycles(2);
    run(3);
    chk("t3_rerun", bus.instruction, 32'h4400_00C8);
    cycles(20);

    // T4: empty program
    run(0);
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_issue", 32'(bus.issue), 0);
    chk("t4_instr", bus.instruction, NOP);
    cycles(2);

    // T5: full 16-word program
    for (int i = 0; i < 16; i++)
      load(i, 32'h1000_0000 + 32'(i));
    run(16);
    issues = int'(bus.issue);
    done_at = -1;
    for (int i = 1; i < 75; i++) begin
      cyc();
      issues += int'(bus.issue);
      if (bus.done && done_at < 0) done_at = i;
    end
    chk("t5_issues", issues, 16);
    chk("t5_done_at", done_at, 68);

    // T1: async reset mid-run
    run(5);
    cycles(5);
    #2 reset = 1'b0;
    #1;
    chk("t1_instr", bus.instruction, NOP);
    chk("t1_pc", 32'(bus.pc), 0);
    chk("t1_busy", 32'(bus.busy), 0);
    chk("t1_done", 32'(bus.done), 0);
    m_mode = M_IDLE;
    m_pc = 0;
    @(negedge clk);
    reset = 1'b1;
    cycles(1);

    // T6: load while busy is dropped
    load(1, 32'h5002_0064);
    run(3);
    cycles(2);
    load(1, 32'hDEAD_BEEF);
    cycles(20);
    run(3);
    cycles(4);
    chk("t6_old", bus.instruction, 32'h5002_0064);
    cycles(20);
    load(0, 32'h4400_00C8);
    bus.prog_len = 5'd3;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    cyc();
    chk("t6_ss_busy", 32'(bus.busy), 0);
    chk("t6_ss_done", 32'(bus.done), 0);
    chk("t6_ss_issue", 32'(bus.issue), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bus.prog_len = 5'($urandom_range(0, 16));
      bus.start = ($urandom_range(0, 19) == 0);
      bus.stop = ($urandom_range(0, 79) == 0);
      if (!bus.start && $urandom_range(0, 5) == 0) begin
        bus.load_en = 1'b1;
        bus.load_addr = 4'($urandom);
        bus.load_data = $urandom;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
